// File: rtl/imem_loader_if.sv
// Stream, IMEM-write and core-control signals shared by the program loader and its environment.
`timescale 1ns/1ps
interface imem_loader_if;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_din;
   logic        core_rst_n;
   logic        done_flag;
   logic [31:0] cycles;
   logic        done;
   logic        timeout;
   logic        err;

   modport master (
      output s_valid, s_data, done_flag,
      input  s_ready, imem_we, imem_addr, imem_din, core_rst_n, cycles, done, timeout, err
   );

   modport slave (
      input  s_valid, s_data, done_flag,
      output s_ready, imem_we, imem_addr, imem_din, core_rst_n, cycles, done, timeout, err
   );
endinterface

// File: rtl/imem_loader.sv
// Byte-stream program loader: fills IMEM from a little-endian byte stream, releases the
// core after a short hold, then supervises the run until done_flag or the cycle budget.
`timescale 1ns/1ps
module imem_loader #(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned MAX_CYCLES  = 1000,
   parameter int unsigned HOLD_CYCLES = 3
) (
   input logic          clk,
   input logic          rst,
   imem_loader_if.slave bus
);
   localparam int unsigned HOLD_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

   localparam logic [2:0] S_HDR0 = 3'd0;
   localparam logic [2:0] S_HDR1 = 3'd1;
   localparam logic [2:0] S_LOAD = 3'd2;
   localparam logic [2:0] S_HOLD = 3'd3;
   localparam logic [2:0] S_RUN  = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;
   localparam logic [2:0] S_ERR  = 3'd6;

   logic [2:0]        state_q, state_n;
   logic [15:0]       n_words_q, n_words_n;
   logic [15:0]       word_idx_q, word_idx_n;
   logic [1:0]        byte_idx_q, byte_idx_n;
   logic [23:0]       word_buf_q, word_buf_n;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_n;
   logic              s_ready_q, s_ready_n;
   logic              imem_we_q, imem_we_n;
   logic [31:0]       imem_addr_q, imem_addr_n;
   logic [31:0]       imem_din_q, imem_din_n;
   logic              core_rst_n_q, core_rst_n_n;
   logic [31:0]       cycles_q, cycles_n;
   logic              done_q, done_n;
   logic              timeout_q, timeout_n;
   logic              err_q, err_n;

   logic              xfer;
   logic [15:0]       hdr_words;

   assign xfer      = s_ready_q & bus.s_valid;
   assign hdr_words = {bus.s_data, n_words_q[7:0]};

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_HDR0;
         n_words_q    <= '0;
         word_idx_q   <= '0;
         byte_idx_q   <= '0;
         word_buf_q   <= '0;
         hold_cnt_q   <= '0;
         s_ready_q    <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_din_q   <= '0;
         core_rst_n_q <= 1'b0;
         cycles_q     <= '0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_n;
         n_words_q    <= n_words_n;
         word_idx_q   <= word_idx_n;
         byte_idx_q   <= byte_idx_n;
         word_buf_q   <= word_buf_n;
         hold_cnt_q   <= hold_cnt_n;
         s_ready_q    <= s_ready_n;
         imem_we_q    <= imem_we_n;
         imem_addr_q  <= imem_addr_n;
         imem_din_q   <= imem_din_n;
         core_rst_n_q <= core_rst_n_n;
         cycles_q     <= cycles_n;
         done_q       <= done_n;
         timeout_q    <= timeout_n;
         err_q        <= err_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n     = state_q;
      n_words_n   = n_words_q;
      word_idx_n  = word_idx_q;
      byte_idx_n  = byte_idx_q;
      word_buf_n  = word_buf_q;
      hold_cnt_n  = hold_cnt_q;
      imem_we_n   = 1'b0;
      imem_addr_n = imem_addr_q;
      imem_din_n  = imem_din_q;
      cycles_n    = cycles_q;
      done_n      = done_q;
      timeout_n   = timeout_q;

      case (state_q)
         S_HDR0: begin
            if (xfer) begin
               n_words_n[7:0] = bus.s_data;
               state_n        = S_HDR1;
            end
         end
         S_HDR1: begin
            if (xfer) begin
               n_words_n[15:8] = bus.s_data;
               word_idx_n      = '0;
               byte_idx_n      = '0;
               if ((hdr_words == 16'd0) || (32'(hdr_words) > DEPTH)) state_n = S_ERR;
               else                                                   state_n = S_LOAD;
            end
         end
         S_LOAD: begin
            if (xfer) begin
               byte_idx_n = byte_idx_q + 2'd1;
               case (byte_idx_q)
                  2'd0:    word_buf_n[7:0]   = bus.s_data;
                  2'd1:    word_buf_n[15:8]  = bus.s_data;
                  2'd2:    word_buf_n[23:16] = bus.s_data;
                  default: begin
                     // Final byte goes straight into the write data, not the buffer
                     imem_we_n   = 1'b1;
                     imem_addr_n = {14'd0, word_idx_q, 2'b00};
                     imem_din_n  = {bus.s_data, word_buf_q};
                     word_idx_n  = word_idx_q + 16'd1;
                     if (word_idx_q == (n_words_q - 16'd1)) begin
                        state_n    = S_HOLD;
                        hold_cnt_n = '0;
                     end
                  end
               endcase
            end
         end
         S_HOLD: begin
            if (hold_cnt_q == HOLD_W'(HOLD_CYCLES)) begin
               state_n  = S_RUN;
               cycles_n = '0;
            end else begin
               hold_cnt_n = hold_cnt_q + HOLD_W'(1);
            end
         end
         S_RUN: begin
            // done_flag takes priority over an exhausted budget
            if (bus.done_flag) begin
               state_n = S_DONE;
               done_n  = 1'b1;
            end else if (cycles_q >= MAX_CYCLES) begin
               state_n   = S_DONE;
               timeout_n = 1'b1;
            end else if (cycles_q != 32'hFFFF_FFFF) begin
               cycles_n = cycles_q + 32'd1;
            end
         end
         default: ;
      endcase

      s_ready_n    = (state_n == S_HDR0) || (state_n == S_HDR1) || (state_n == S_LOAD);
      core_rst_n_n = (state_n == S_RUN) || ((state_n == S_DONE) && done_n);
      err_n        = (state_n == S_ERR);
   end

   assign bus.s_ready    = s_ready_q;
   assign bus.imem_we    = imem_we_q;
   assign bus.imem_addr  = imem_addr_q;
   assign bus.imem_din   = imem_din_q;
   assign bus.core_rst_n = core_rst_n_q;
   assign bus.cycles     = cycles_q;
   assign bus.done       = done_q;
   assign bus.timeout    = timeout_q;
   assign bus.err        = err_q;
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Byte-stream program loader. It writes instruction words into the pipelined core's IMEM, releases the core's reset, then watches `done_flag` until completion or timeout.

Interface — parameters
REQ-001 DEPTH, default 64: number of IMEM words; also the maximum legal word count.
REQ-002 MAX_CYCLES, default 1000: run-cycle budget before timeout.
REQ-003 HOLD_CYCLES, default 3: number of cycles `core_rst_n` stays low after the last IMEM write.

Interface — ports
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 s_valid  in  1  stream byte valid.
REQ-007 s_data  in  8  stream byte.
REQ-008 s_ready  out  1  loader can accept a byte.
REQ-009 imem_we  out  1  IMEM write strobe, one cycle per word.
REQ-010 imem_addr  out  32  IMEM byte address (word index × 4).
REQ-011 imem_din  out  32  IMEM write data.
REQ-012 core_rst_n  out  1  core reset, active-low (matches the core's rst polarity).
REQ-013 done_flag  in  1  core program-complete indication.
REQ-014 cycles  out  32  run cycles counted since core release.
REQ-015 done  out  1  core reported done.
REQ-016 timeout  out  1  run budget exhausted.
REQ-017 err  out  1  illegal header received.

Function
REQ-018 A byte transfers only in a cycle where s_valid=1 and s_ready=1; s_ready=1 only in states HDR0, HDR1 and LOAD.
REQ-019 The FSM SHALL have states HDR0, HDR1, LOAD, HOLD, RUN, DONE, ERR.
REQ-020 HDR0: transferred byte becomes N[7:0]; go to HDR1.
REQ-021 HDR1: transferred byte becomes N[15:8]; if N=0 or N>DEPTH go to ERR, else go to LOAD with word index 0 and byte index 0.
REQ-022 LOAD: transferred bytes are assembled little-endian (first byte → bits [7:0]); byte index wraps 3→0.
REQ-023 When byte 3 of word i transfers in cycle k, imem_we=1 in cycle k+1, with imem_addr=4·i and imem_din=the assembled word; imem_we=0 in all other cycles.
REQ-024 Gaps in s_valid SHALL NOT corrupt assembly; back-to-back bytes SHALL sustain one byte per cycle.
REQ-025 After byte 3 of word N-1 transfers, go to HOLD; s_ready=0 from the next cycle.
REQ-026 HOLD: core_rst_n stays 0 for HOLD_CYCLES cycles after the final imem_we pulse; then go to RUN with core_rst_n=1 and cycles=0.
REQ-027 core_rst_n=0 in every state except RUN and DONE-with-done=1.
REQ-028 RUN: if done_flag=1 is sampled, go to DONE with done=1 and cycles frozen.
REQ-029 RUN: otherwise cycles increments by 1 each cycle.
REQ-030 RUN: if cycles reaches MAX_CYCLES with done_flag=0, go to DONE with timeout=1 and core_rst_n=0.
REQ-031 done and timeout SHALL never both be 1.
REQ-032 done_flag SHALL be ignored in every state other than RUN.
REQ-033 If done_flag=1 on the same cycle cycles reaches MAX_CYCLES, done wins.
REQ-034 ERR: err=1 and s_ready=0; ERR and DONE are terminal, left only by rst.
REQ-035 The cycles counter SHALL saturate and never wrap.

Reset
REQ-036 While rst=1, and immediately on its assertion: state=HDR0, s_ready=0, imem_we=0, imem_addr=0, imem_din=0, core_rst_n=0, cycles=0, done=0, timeout=0, err=0.
REQ-037 s_ready rises the first cycle after rst deasserts.
REQ-038 rst mid-LOAD SHALL discard the partial word and count; no imem_we pulse is issued for it.

Verification
REQ-039 Normal load: header 02 00, then bytes 93 00 50 00 13 01 A0 00 → imem_we pulses at addr 0x0 (data 0x00500093) and addr 0x4 (data 0x00A00113); core_rst_n rises 3 cycles after the second pulse.
REQ-040 Bad header: header 00 00 → err=1, s_ready=0, core_rst_n=0 indefinitely; header 41 00 with DEPTH=64 → same.
REQ-041 Done detection: after release, done_flag held 0 for 20 cycles then driven 1 → done=1, cycles=20, core_rst_n stays 1.
REQ-042 Timeout: with MAX_CYCLES=50, done_flag never asserted → timeout=1, cycles=50, core_rst_n=0, done=0.
REQ-043 Reset mid-load: rst pulsed after 5 bytes of a 2-word load, then a fresh 1-word load → exactly one imem_we, at addr 0x0 with the new data.
REQ-044 Throttled stream: random s_valid gaps and a spurious done_flag during LOAD → same IMEM writes as back-to-back, and done=0 until RUN.
